program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 118 +++++++++++
 tb/tb_program_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream instruction memory loader; optional checksum via PROGRAM_LOADER_CHECKSUM_EN
module program_loader #(
  parameter int NB_INSTR           = 32,
  parameter int N_ADDR             = 512,
  parameter int LOG2_N_INSMEM_ADDR = 10
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_rx_valid,
  output logic                          o_rx_ready,
  output logic                          o_imem_wr_en,
  output logic [LOG2_N_INSMEM_ADDR-1:0] o_imem_addr,
  output logic [NB_INSTR-1:0]           o_imem_data,
  output logic                          o_pipe_reset,
  output logic                          o_pipe_valid,
  output logic                          o_done,
  output logic                          o_error
);

  localparam logic [LOG2_N_INSMEM_ADDR-1:0] LAST_ADDR = LOG2_N_INSMEM_ADDR'(N_ADDR - 1);
  localparam logic [LOG2_N_INSMEM_ADDR-1:0] ADDR_ONE  = LOG2_N_INSMEM_ADDR'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ASSEMBLE = 3'd1,
    WRITE    = 3'd2,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    CHECK    = 3'd3,
`endif
    RUN      = 3'd4,
    ERROR    = 3'd5
  } state_t;

  state_t               state, next_state;
  logic [1:0]           byte_cnt;
  logic [NB_INSTR-9:0]  shift_q;   // first three bytes of the word being built
  logic                 accept;
  logic                 loading;
  logic                 is_halt;
  logic                 ready_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]           checksum;
`endif

  // Next-state decode: byte acceptance, word completion and post-write routing
  always_comb begin
    next_state = state;
    accept     = i_rx_valid && o_rx_ready;
    loading    = (state == IDLE) || (state == ASSEMBLE);
    is_halt    = (o_imem_data == '1);
    case (state)
      IDLE:     if (accept) next_state = ASSEMBLE;
      ASSEMBLE: if (accept && byte_cnt == 2'd3) next_state = WRITE;
      WRITE: begin
        if (is_halt) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          next_state = CHECK;
`else
          next_state = RUN;
`endif
        end else if (o_imem_addr == LAST_ADDR) begin
          next_state = ERROR;
        end else begin
          next_state = IDLE;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK:    if (accept) next_state = (i_rx_data == checksum) ? RUN : ERROR;
`endif
      RUN:      next_state = RUN;
      ERROR:    next_state = ERROR;
      default:  next_state = IDLE;
    endcase
    ready_next = (next_state == IDLE) || (next_state == ASSEMBLE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (next_state == CHECK) ready_next = 1'b1;
`endif
  end

  // State, datapath and registered outputs; outputs follow next_state so they are valid on state entry
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      byte_cnt     <= 2'd0;
      shift_q      <= '0;
      o_imem_addr  <= '0;
      o_imem_data  <= '0;
      o_imem_wr_en <= 1'b0;
      o_rx_ready   <= 1'b0;
      o_pipe_reset <= 1'b1;
      o_pipe_valid <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      checksum     <= 8'd0;
`endif
    end else begin
      state        <= next_state;
      o_imem_wr_en <= (next_state == WRITE);
      o_rx_ready   <= ready_next;
      o_pipe_reset <= (next_state != RUN);
      o_pipe_valid <= (next_state == RUN);
      o_done       <= (next_state == RUN);
      o_error      <= (next_state == ERROR);
      if (accept && loading) begin
        shift_q  <= {shift_q[NB_INSTR-17:0], i_rx_data};
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) o_imem_data <= {shift_q, i_rx_data};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        checksum <= checksum ^ i_rx_data;
`endif
      end
      if (state == WRITE && !is_halt) o_imem_addr <= o_imem_addr + ADDR_ONE;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  logic        tb_clock_i;
  logic        i_reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic        o_imem_wr_en;
  logic [9:0]  o_imem_addr;
  logic [31:0] o_imem_data;
  logic        o_pipe_reset;
  logic        o_pipe_valid;
  logic        o_done;
  logic        o_error;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  logic [9:0]  wr_addr [0:599];
  logic [31:0] wr_data [0:599];

  program_loader dut (
    .i_clock      (tb_clock_i),
    .i_reset      (i_reset),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_rx_ready   (o_rx_ready),
    .o_imem_wr_en (o_imem_wr_en),
    .o_imem_addr  (o_imem_addr),
    .o_imem_data  (o_imem_data),
    .o_pipe_reset (o_pipe_reset),
    .o_pipe_valid (o_pipe_valid),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  initial tb_clock_i = 1'b0;
  always #5 tb_clock_i = ~tb_clock_i;

  // Record every memory write, sampled mid-cycle
  always @(negedge tb_clock_i) begin
    if (o_imem_wr_en) begin
      if (wr_cnt < 600) begin
        wr_addr[wr_cnt] = o_imem_addr;
        wr_data[wr_cnt] = o_imem_data;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!o_rx_ready && n < 20) begin
      @(negedge tb_clock_i);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $error("FAIL send_timeout observed=ready0 expected=ready1");
    end
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge tb_clock_i);
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic do_reset();
    @(negedge tb_clock_i);
    i_reset = 1'b1;
    @(negedge tb_clock_i);
    i_reset = 1'b0;
    wr_cnt  = 0;
    @(negedge tb_clock_i);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!o_done && !o_error && n < 20) begin
      @(negedge tb_clock_i);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $error("FAIL end_timeout observed=none expected=done_or_error");
    end
  endtask

  initial begin
    i_reset    = 1'b1;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    @(negedge tb_clock_i);
    @(negedge tb_clock_i);

    // reset state
    check("rst_ready",  {31'd0, o_rx_ready},   32'd0);
    check("rst_wr_en",  {31'd0, o_imem_wr_en}, 32'd0);
    check("rst_addr",   {22'd0, o_imem_addr},  32'd0);
    check("rst_data",   o_imem_data,           32'd0);
    check("rst_preset", {31'd0, o_pipe_reset}, 32'd1);
    check("rst_pvalid", {31'd0, o_pipe_valid}, 32'd0);
    check("rst_done",   {31'd0, o_done},       32'd0);
    check("rst_error",  {31'd0, o_error},      32'd0);
    i_reset = 1'b0;
    @(negedge tb_clock_i);
    check("ready_after_rst", {31'd0, o_rx_ready}, 32'd1);

    // basic load
    send_word(32'h20080005);
    send_word(32'hFFFFFFFF);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h2D);
`endif
    wait_end();
    check("basic_wr_cnt", wr_cnt,        32'd2);
    check("basic_a0",     {22'd0, wr_addr[0]}, 32'd0);
    check("basic_d0",     wr_data[0],    32'h20080005);
    check("basic_a1",     {22'd0, wr_addr[1]}, 32'd1);
    check("basic_d1",     wr_data[1],    32'hFFFFFFFF);
    check("basic_done",   {31'd0, o_done},       32'd1);
    check("basic_preset", {31'd0, o_pipe_reset}, 32'd0);
    check("basic_pvalid", {31'd0, o_pipe_valid}, 32'd1);
    check("basic_error",  {31'd0, o_error},      32'd0);
    check("basic_addr",   {22'd0, o_imem_addr},  32'd1);

    // bytes presented in RUN are refused
    for (int i = 0; i < 6; i++) begin
      i_rx_data  = 8'h40 + 8'(i);
      i_rx_valid = 1'b1;
      @(negedge tb_clock_i);
      check("run_ready", {31'd0, o_rx_ready}, 32'd0);
    end
    i_rx_valid = 1'b0;
    @(negedge tb_clock_i);
    check("run_wr_cnt", wr_cnt,          32'd2);
    check("run_done",   {31'd0, o_done}, 32'd1);

    // reset mid-word discards the partial word
    do_reset();
    send_byte(8'hAA);
    send_byte(8'hBB);
    i_reset = 1'b1;
    #2;
    i_reset = 1'b0;
    check("midrst_ready", {31'd0, o_rx_ready}, 32'd0);
    check("midrst_nowr",  wr_cnt, 32'd0);
    send_word(32'h12345678);
    send_word(32'hFFFFFFFF);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78);
`endif
    wait_end();
    check("midrst_a0",   {22'd0, wr_addr[0]}, 32'd0);
    check("midrst_d0",   wr_data[0], 32'h12345678);
    check("midrst_done", {31'd0, o_done}, 32'd1);

    // byte offered during the WRITE cycle is dropped
    do_reset();
    send_word(32'h01020304);
    check("wc_wr_en",  {31'd0, o_imem_wr_en}, 32'd1);
    check("wc_data",   o_imem_data, 32'h01020304);
    check("wc_ready",  {31'd0, o_rx_ready}, 32'd0);
    i_rx_data  = 8'h99;
    i_rx_valid = 1'b1;
    @(negedge tb_clock_i);
    i_rx_valid = 1'b0;
    check("wc_wr_pulse", {31'd0, o_imem_wr_en}, 32'd0);
    send_word(32'h05060708);
    send_word(32'hFFFFFFFF);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04 ^ 8'h05 ^ 8'h06 ^ 8'h07 ^ 8'h08);
`endif
    wait_end();
    check("wc_cnt", wr_cnt, 32'd3);
    check("wc_d1",  wr_data[1], 32'h05060708);
    check("wc_a1",  {22'd0, wr_addr[1]}, 32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // bad checksum
    do_reset();
    send_word(32'h20080005);
    send_word(32'hFFFFFFFF);
    send_byte(8'h00);
    wait_end();
    check("badck_error",  {31'd0, o_error},      32'd1);
    check("badck_pvalid", {31'd0, o_pipe_valid}, 32'd0);
    check("badck_done",   {31'd0, o_done},       32'd0);
`endif

    // overflow: 512 non-halt words
    do_reset();
    for (int i = 0; i < 512; i++) send_word(32'h00AB0000 | 32'(i));
    wait_end();
    check("ovf_cnt",    wr_cnt, 32'd512);
    check("ovf_a_last", {22'd0, wr_addr[511]}, 32'd511);
    check("ovf_d_last", wr_data[511], 32'h00AB01FF);
    check("ovf_d_first", wr_data[0], 32'h00AB0000);
    check("ovf_error",  {31'd0, o_error},      32'd1);
    check("ovf_preset", {31'd0, o_pipe_reset}, 32'd1);
    check("ovf_pvalid", {31'd0, o_pipe_valid}, 32'd0);
    check("ovf_done",   {31'd0, o_done},       32'd0);
    check("ovf_ready",  {31'd0, o_rx_ready},   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
